// File: rtl/game_flow_ctrl.sv
// Game/menu sequencer: screen state machine, button hit-testing, stage progress and countdown timer.
// All HUD outputs are registered; click and event effects appear one clock after the input pulse.
module game_flow_ctrl #(
   parameter int unsigned CLK_PER_SEC   = 25_000_000,
   parameter int unsigned STAGE_SECONDS = 99,
   parameter int unsigned KEYS_NEEDED   = 3,
   parameter int unsigned GUARD_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       click,
   input  logic [8:0] click_x,
   input  logic [8:0] click_y,
   input  logic       ev_key,
   input  logic       ev_light,
   input  logic       ev_door,
   input  logic       ev_hit,
   output logic [3:0] state,
   output logic [1:0] key_find,
   output logic [1:0] life,
   output logic [1:0] todo,
   output logic [3:0] play_valid,
   output logic [7:0] time_left,
   output logic       stage_start
);

   localparam int unsigned TICK_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int unsigned GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(CLK_PER_SEC - 1);
   localparam logic [GUARD_W-1:0] GUARD_LD  = GUARD_W'(GUARD_CYCLES);
   localparam logic [1:0]         KEY_MAX   = 2'(KEYS_NEEDED);
   localparam logic [7:0]         TIME_LD   = 8'(STAGE_SECONDS);

   typedef enum logic [3:0] {
      ST_TITLE    = 4'd0,
      ST_STAFF    = 4'd1,
      ST_STAGE1   = 4'd2,
      ST_SUCCESS1 = 4'd3,
      ST_STAGE2   = 4'd4,
      ST_SUCCESS2 = 4'd5,
      ST_STAGE3   = 4'd6,
      ST_SUCCESS3 = 4'd7,
      ST_FAIL     = 4'd8,
      ST_HELP     = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      TD_NONE       = 2'd0,
      TD_FIND_KEY   = 2'd1,
      TD_FIND_LIGHT = 2'd2,
      TD_FIND_DOOR  = 2'd3
   } todo_t;

   state_t              state_q, state_d;
   state_t              retry_q, retry_d;
   todo_t               todo_q, todo_d;
   logic [1:0]          key_q, key_d;
   logic [1:0]          life_q, life_d;
   logic [3:0]          pv_q, pv_d;
   logic [7:0]          time_q, time_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [GUARD_W-1:0]  guard_q, guard_d;
   logic                start_q, start_d;
   logic                click_ok;
   logic                wrap;
   logic                expire;

   function automatic logic is_stage(input state_t s);
      return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
   endfunction

   // Buttons are 80x20 boxes at x 120..199, inclusive-low / exclusive-high.
   function automatic logic in_box(input logic [8:0] x, input logic [8:0] y, input logic [8:0] y0);
      return (x >= 9'd120) && (x < 9'd200) && (y >= y0) && (y < (y0 + 9'd20));
   endfunction

   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      todo_d   = todo_q;
      key_d    = key_q;
      life_d   = life_q;
      pv_d     = pv_q;
      time_d   = time_q;
      tick_d   = '0;
      guard_d  = guard_q;
      start_d  = 1'b0;
      wrap     = (tick_q == TICK_MAX);
      expire   = 1'b0;
      click_ok = click && (guard_q == '0) && !is_stage(state_q);

      if (guard_q != '0) guard_d = guard_q - 1'b1;

      if (is_stage(state_q)) begin
         tick_d = wrap ? '0 : tick_q + 1'b1;
         if (wrap && (time_q != '0)) time_d = time_q - 8'd1;
         expire = wrap && (time_q <= 8'd1);

         // Strict priority chain: only the highest-priority qualifying event acts.
         if (ev_door && (todo_q == TD_FIND_DOOR)) begin
            todo_d = TD_NONE;
            case (state_q)
               ST_STAGE1: begin state_d = ST_SUCCESS1; pv_d[2] = 1'b1; end
               ST_STAGE2: begin state_d = ST_SUCCESS2; pv_d[3] = 1'b1; end
               default:         state_d = ST_SUCCESS3;
            endcase
         end else if (ev_hit && (state_q == ST_STAGE3)) begin
            if (life_q <= 2'd1) begin
               life_d  = '0;
               state_d = ST_FAIL;
            end else begin
               life_d = life_q - 2'd1;
            end
         end else if (expire) begin
            state_d = ST_FAIL;
         end else if (ev_key && (todo_q == TD_FIND_KEY)) begin
            if (key_q < KEY_MAX) key_d = key_q + 2'd1;
            if ((key_q + 2'd1) >= KEY_MAX) todo_d = TD_FIND_DOOR;
         end else if (ev_light && (todo_q == TD_FIND_LIGHT)) begin
            todo_d = TD_FIND_KEY;
         end
      end else if (click_ok) begin
         case (state_q)
            ST_TITLE: begin
               if (in_box(click_x, click_y, 9'd120))                  state_d = ST_STAGE1;
               else if (in_box(click_x, click_y, 9'd150) && pv_q[2])  state_d = ST_STAGE2;
               else if (in_box(click_x, click_y, 9'd180) && pv_q[3])  state_d = ST_STAGE3;
               else if (in_box(click_x, click_y, 9'd210))             state_d = ST_HELP;
            end
            ST_SUCCESS1: begin
               if (in_box(click_x, click_y, 9'd140))      state_d = ST_STAGE2;
               else if (in_box(click_x, click_y, 9'd180)) state_d = ST_TITLE;
            end
            ST_SUCCESS2: begin
               if (in_box(click_x, click_y, 9'd140))      state_d = ST_STAGE3;
               else if (in_box(click_x, click_y, 9'd180)) state_d = ST_TITLE;
            end
            ST_SUCCESS3: if (in_box(click_x, click_y, 9'd150)) state_d = ST_STAFF;
            ST_FAIL: begin
               if (in_box(click_x, click_y, 9'd140))      state_d = retry_q;
               else if (in_box(click_x, click_y, 9'd180)) state_d = ST_TITLE;
            end
            ST_STAFF: if (in_box(click_x, click_y, 9'd180)) state_d = ST_TITLE;
            ST_HELP:  if (in_box(click_x, click_y, 9'd200)) state_d = ST_TITLE;
            default: ;
         endcase
      end

      // Any transition rearms the click guard; entering a stage overrides all per-stage values.
      if (state_d != state_q) begin
         guard_d = GUARD_LD;
         if (is_stage(state_d)) begin
            key_d   = '0;
            life_d  = 2'd3;
            time_d  = TIME_LD;
            tick_d  = '0;
            retry_d = state_d;
            todo_d  = (state_d == ST_STAGE2) ? TD_FIND_LIGHT : TD_FIND_KEY;
            start_d = 1'b1;
         end else begin
            tick_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_TITLE;
         retry_q <= ST_STAGE1;
         todo_q  <= TD_NONE;
         key_q   <= '0;
         life_q  <= 2'd3;
         pv_q    <= 4'b0011;
         time_q  <= '0;
         tick_q  <= '0;
         guard_q <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         todo_q  <= todo_d;
         key_q   <= key_d;
         life_q  <= life_d;
         pv_q    <= pv_d;
         time_q  <= time_d;
         tick_q  <= tick_d;
         guard_q <= guard_d;
         start_q <= start_d;
      end
   end

   assign state       = state_q;
   assign key_find    = key_q;
   assign life        = life_q;
   assign todo        = todo_q;
   assign play_valid  = pv_q;
   assign time_left   = time_q;
   assign stage_start = start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: one instance with a short guard for menu/stage flow,
// a second with a tiny second/stage length for the countdown timer.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       click = 1'b0;
   logic [8:0] click_x = '0;
   logic [8:0] click_y = '0;
   logic       ev_key = 1'b0, ev_light = 1'b0, ev_door = 1'b0, ev_hit = 1'b0;

   logic [3:0] a_state, a_pv, b_state, b_pv;
   logic [1:0] a_key, a_life, a_todo, b_key, b_life, b_todo;
   logic [7:0] a_time, b_time;
   logic       a_start, b_start;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   game_flow_ctrl #(.GUARD_CYCLES(64)) dut_a (
      .clk(clk), .rst(rst), .click(click), .click_x(click_x), .click_y(click_y),
      .ev_key(ev_key), .ev_light(ev_light), .ev_door(ev_door), .ev_hit(ev_hit),
      .state(a_state), .key_find(a_key), .life(a_life), .todo(a_todo),
      .play_valid(a_pv), .time_left(a_time), .stage_start(a_start)
   );

   game_flow_ctrl #(.CLK_PER_SEC(4), .STAGE_SECONDS(2), .GUARD_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .click(click), .click_x(click_x), .click_y(click_y),
      .ev_key(ev_key), .ev_light(ev_light), .ev_door(ev_door), .ev_hit(ev_hit),
      .state(b_state), .key_find(b_key), .life(b_life), .todo(b_todo),
      .play_valid(b_pv), .time_left(b_time), .stage_start(b_start)
   );

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   task automatic do_click(input int x, input int y);
      click = 1'b1; click_x = 9'(x); click_y = 9'(y);
      idle(1);
      click = 1'b0;
   endtask

   task automatic pulse(input logic k, input logic l, input logic d, input logic h);
      ev_key = k; ev_light = l; ev_door = d; ev_hit = h;
      idle(1);
      ev_key = 1'b0; ev_light = 1'b0; ev_door = 1'b0; ev_hit = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", a_state); end
      vectors++; if (a_key !== 2'd0) begin miscompares++; $display("FAIL rst_key: got %0d expected 0", a_key); end
      vectors++; if (a_life !== 2'd3) begin miscompares++; $display("FAIL rst_life: got %0d expected 3", a_life); end
      vectors++; if (a_todo !== 2'd0) begin miscompares++; $display("FAIL rst_todo: got %0d expected 0", a_todo); end
      vectors++; if (a_pv !== 4'b0011) begin miscompares++; $display("FAIL rst_pv: got %b expected 0011", a_pv); end
      vectors++; if (a_time !== 8'd0) begin miscompares++; $display("FAIL rst_time: got %0d expected 0", a_time); end
      vectors++; if (a_start !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %0d expected 0", a_start); end
   endtask

   task automatic test_enter_stage1();
      do_click(150, 125);
      vectors++; if (a_state !== 4'd2) begin miscompares++; $display("FAIL s1_state: got %0d expected 2", a_state); end
      vectors++; if (a_todo !== 2'd1) begin miscompares++; $display("FAIL s1_todo: got %0d expected 1", a_todo); end
      vectors++; if (a_life !== 2'd3) begin miscompares++; $display("FAIL s1_life: got %0d expected 3", a_life); end
      vectors++; if (a_time !== 8'd99) begin miscompares++; $display("FAIL s1_time: got %0d expected 99", a_time); end
      vectors++; if (a_start !== 1'b1) begin miscompares++; $display("FAIL s1_start_hi: got %0d expected 1", a_start); end
      idle(1);
      vectors++; if (a_start !== 1'b0) begin miscompares++; $display("FAIL s1_start_lo: got %0d expected 0", a_start); end
   endtask

   task automatic test_keys_door();
      do_click(150, 145);
      vectors++; if (a_state !== 4'd2) begin miscompares++; $display("FAIL stage_click_ignored: got %0d expected 2", a_state); end
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd1) begin miscompares++; $display("FAIL key1: got %0d expected 1", a_key); end
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd2 || a_todo !== 2'd1) begin miscompares++; $display("FAIL key2: got key %0d todo %0d expected 2/1", a_key, a_todo); end
      pulse(0, 0, 1, 0);
      vectors++; if (a_state !== 4'd2) begin miscompares++; $display("FAIL early_door: got %0d expected 2", a_state); end
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd3 || a_todo !== 2'd3) begin miscompares++; $display("FAIL key3: got key %0d todo %0d expected 3/3", a_key, a_todo); end
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd3) begin miscompares++; $display("FAIL key_sat: got %0d expected 3", a_key); end
      pulse(0, 0, 1, 0);
      vectors++; if (a_state !== 4'd3 || a_pv !== 4'b0111 || a_todo !== 2'd0) begin miscompares++; $display("FAIL door1: got st %0d pv %b todo %0d expected 3/0111/0", a_state, a_pv, a_todo); end
   endtask

   task automatic test_guard();
      idle(64);
      do_click(150, 185);
      vectors++; if (a_state !== 4'd0 || a_pv !== 4'b0111) begin miscompares++; $display("FAIL back_title: got st %0d pv %b expected 0/0111", a_state, a_pv); end
      idle(63);
      do_click(150, 155);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL guard_block: got %0d expected 0", a_state); end
      do_click(150, 155);
      vectors++; if (a_state !== 4'd4 || a_todo !== 2'd2 || a_time !== 8'd99) begin miscompares++; $display("FAIL s2_enter: got st %0d todo %0d time %0d expected 4/2/99", a_state, a_todo, a_time); end
   endtask

   task automatic test_stage2();
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd0 || a_todo !== 2'd2) begin miscompares++; $display("FAIL s2_key_early: got key %0d todo %0d expected 0/2", a_key, a_todo); end
      pulse(1, 1, 0, 0);
      vectors++; if (a_key !== 2'd0 || a_todo !== 2'd1) begin miscompares++; $display("FAIL s2_key_light: got key %0d todo %0d expected 0/1", a_key, a_todo); end
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      vectors++; if (a_key !== 2'd3 || a_todo !== 2'd3) begin miscompares++; $display("FAIL s2_keys: got key %0d todo %0d expected 3/3", a_key, a_todo); end
      pulse(0, 0, 1, 0);
      vectors++; if (a_state !== 4'd5 || a_pv !== 4'b1111) begin miscompares++; $display("FAIL door2: got st %0d pv %b expected 5/1111", a_state, a_pv); end
   endtask

   task automatic test_stage3();
      idle(64);
      do_click(150, 145);
      vectors++; if (a_state !== 4'd6 || a_todo !== 2'd1 || a_life !== 2'd3) begin miscompares++; $display("FAIL s3_enter: got st %0d todo %0d life %0d expected 6/1/3", a_state, a_todo, a_life); end
      pulse(0, 0, 0, 1);
      vectors++; if (a_life !== 2'd2) begin miscompares++; $display("FAIL hit1: got %0d expected 2", a_life); end
      pulse(0, 0, 0, 1);
      vectors++; if (a_life !== 2'd1 || a_state !== 4'd6) begin miscompares++; $display("FAIL hit2: got life %0d st %0d expected 1/6", a_life, a_state); end
      pulse(0, 0, 0, 1);
      vectors++; if (a_life !== 2'd0 || a_state !== 4'd8) begin miscompares++; $display("FAIL hit3: got life %0d st %0d expected 0/8", a_life, a_state); end
      idle(64);
      do_click(150, 145);
      vectors++; if (a_state !== 4'd6 || a_life !== 2'd3 || a_start !== 1'b1) begin miscompares++; $display("FAIL retry: got st %0d life %0d start %0d expected 6/3/1", a_state, a_life, a_start); end
      pulse(0, 1, 0, 0);
      vectors++; if (a_todo !== 2'd1) begin miscompares++; $display("FAIL s3_light_ign: got %0d expected 1", a_todo); end
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 1);
      vectors++; if (a_key !== 2'd2 || a_life !== 2'd2) begin miscompares++; $display("FAIL hit_over_key: got key %0d life %0d expected 2/2", a_key, a_life); end
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 1);
      vectors++; if (a_state !== 4'd7 || a_life !== 2'd2 || a_todo !== 2'd0) begin miscompares++; $display("FAIL door_over_hit: got st %0d life %0d todo %0d expected 7/2/0", a_state, a_life, a_todo); end
      idle(64);
      do_click(150, 155);
      vectors++; if (a_state !== 4'd1) begin miscompares++; $display("FAIL to_staff: got %0d expected 1", a_state); end
      idle(64);
      do_click(150, 185);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL staff_title: got %0d expected 0", a_state); end
   endtask

   task automatic test_title_locked();
      do_reset();
      do_click(150, 185);
      vectors++; if (a_state !== 4'd0 || a_pv !== 4'b0011) begin miscompares++; $display("FAIL locked3: got st %0d pv %b expected 0/0011", a_state, a_pv); end
      do_click(150, 155);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL locked2: got %0d expected 0", a_state); end
      do_click(200, 125);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL x_excl_high: got %0d expected 0", a_state); end
      do_click(150, 140);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL y_excl_high: got %0d expected 0", a_state); end
      do_click(150, 210);
      vectors++; if (a_state !== 4'd9) begin miscompares++; $display("FAIL to_help: got %0d expected 9", a_state); end
      idle(64);
      do_click(150, 219);
      vectors++; if (a_state !== 4'd0) begin miscompares++; $display("FAIL help_title: got %0d expected 0", a_state); end
   endtask

   task automatic test_timer();
      do_reset();
      do_click(150, 125);
      vectors++; if (b_state !== 4'd2 || b_time !== 8'd2) begin miscompares++; $display("FAIL t_enter: got st %0d time %0d expected 2/2", b_state, b_time); end
      idle(3);
      vectors++; if (b_time !== 8'd2) begin miscompares++; $display("FAIL t_pre_wrap: got %0d expected 2", b_time); end
      idle(1);
      vectors++; if (b_time !== 8'd1 || b_state !== 4'd2) begin miscompares++; $display("FAIL t_wrap1: got time %0d st %0d expected 1/2", b_time, b_state); end
      idle(4);
      vectors++; if (b_time !== 8'd0 || b_state !== 4'd8) begin miscompares++; $display("FAIL t_expire: got time %0d st %0d expected 0/8", b_time, b_state); end
      idle(6);
      vectors++; if (b_time !== 8'd0 || b_state !== 4'd8) begin miscompares++; $display("FAIL t_frozen: got time %0d st %0d expected 0/8", b_time, b_state); end
      do_click(150, 145);
      vectors++; if (b_state !== 4'd2 || b_time !== 8'd2) begin miscompares++; $display("FAIL t_retry: got st %0d time %0d expected 2/2", b_state, b_time); end
      pulse(1, 0, 0, 0);
      do_reset();
      vectors++; if (b_state !== 4'd0 || b_key !== 2'd0 || b_life !== 2'd3 || b_todo !== 2'd0) begin miscompares++; $display("FAIL t_rst_a: got st %0d key %0d life %0d todo %0d expected 0/0/3/0", b_state, b_key, b_life, b_todo); end
      vectors++; if (b_pv !== 4'b0011 || b_time !== 8'd0 || b_start !== 1'b0) begin miscompares++; $display("FAIL t_rst_b: got pv %b time %0d start %0d expected 0011/0/0", b_pv, b_time, b_start); end
   endtask

   initial begin
      idle(1);
      test_reset();
      test_enter_stage1();
      test_keys_door();
      test_guard();
      test_stage2();
      test_stage3();
      test_title_locked();
      test_timer();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
